// File: rtl/scr1_pipe_mprf_mp.sv
// -----------------------------------------------------------------------------
// scr1_pipe_mprf_mp
//
// Parametrised multi-port register file with NRD registered read ports and
// NWR write ports over a SIZE x XLEN array. An integrated clear sequencer
// zeroes every entry after reset and whenever init_req_i is seen while idle.
//
// Build option:
//   SCR1_MPRF_MP_FWD_EN  defined   -> write-first: a read that collides with a
//                                     valid same-cycle write returns the new data
//                        undefined -> read-first: the colliding read returns the
//                                     old contents
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rd_en_i      per-port read enable (NRD)
//   rd_addr_i    read addresses, port k at [k*AWIDTH +: AWIDTH]
//   rd_data_o    registered read data, port k at [k*XLEN +: XLEN]
//   wr_req_i     per-port write request (NWR)
//   wr_addr_i    write addresses, port j at [j*AWIDTH +: AWIDTH]
//   wr_data_i    write data, port j at [j*XLEN +: XLEN]
//   init_req_i   request a new clear sequence (honoured only when idle)
//   busy_o       clear sequence in progress
//   wr_drop_o    one-cycle pulse: a write was discarded while busy
//
// Handshake: there is no backpressure. A write is accepted on any edge where
// busy_o is low; a write presented while busy_o is high is discarded and
// reported on wr_drop_o one cycle later. Reads always complete with a fixed
// one-cycle latency; while busy_o is high they return zero.
// -----------------------------------------------------------------------------
module scr1_pipe_mprf_mp #(
  parameter int XLEN     = 32,
  parameter int AWIDTH   = 5,
  parameter int SIZE     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0]         rd_en_i,
  input  logic [NRD*AWIDTH-1:0]  rd_addr_i,
  output logic [NRD*XLEN-1:0]    rd_data_o,
  input  logic [NWR-1:0]         wr_req_i,
  input  logic [NWR*AWIDTH-1:0]  wr_addr_i,
  input  logic [NWR*XLEN-1:0]    wr_data_i,
  input  logic                   init_req_i,
  output logic                   busy_o,
  output logic                   wr_drop_o
);

  // Entry 0 is never cleared when it is hardwired, so the walk starts at 1.
  localparam int                FIRST   = (ZERO_REG != 0) ? 1 : 0;
  localparam logic [AWIDTH-1:0] FIRST_A = AWIDTH'(FIRST);
  localparam logic [AWIDTH-1:0] LAST_A  = AWIDTH'(SIZE - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   ptr_q, ptr_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic                wr_drop_q, wr_drop_d;

  logic [XLEN-1:0]     mem_q [SIZE];

  // Unpacked views of the flat port buses.
  logic [AWIDTH-1:0]   wa    [NWR];
  logic [XLEN-1:0]     wd    [NWR];
  logic                wv    [NWR];
  logic [AWIDTH-1:0]   ra    [NRD];

  // Per-entry write strobe and data.
  logic [SIZE-1:0]     ent_we;
  logic [XLEN-1:0]     ent_wd [SIZE];

  logic                busy;

  // An address is writable/readable when it is inside the array and is not
  // the hardwired zero entry.
  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (int'(a) < SIZE);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j] = wr_addr_i[j*AWIDTH +: AWIDTH];
      wd[j] = wr_data_i[j*XLEN +: XLEN];
      wv[j] = wr_req_i[j] && addr_ok(wr_addr_i[j*AWIDTH +: AWIDTH]);
    end
    for (int k = 0; k < NRD; k++) begin
      ra[k] = rd_addr_i[k*AWIDTH +: AWIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_A) begin
          state_d = ST_READY;
          ptr_d   = FIRST_A;
        end else begin
          ptr_d = ptr_q + AWIDTH'(1);
        end
      end
      ST_READY: begin
        if (init_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = FIRST_A;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = FIRST_A;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write selection. While clearing, only the pointer entry is written
  // (with zero) and external writes are discarded. When ready, ports are
  // scanned in ascending order so the highest-index port wins a collision.
  // ---------------------------------------------------------------------------
  always_comb begin
    ent_we = '0;
    for (int i = 0; i < SIZE; i++) begin
      ent_wd[i] = '0;
    end
    if (busy) begin
      for (int i = 0; i < SIZE; i++) begin
        if (ptr_q == AWIDTH'(i)) begin
          ent_we[i] = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        for (int i = 0; i < SIZE; i++) begin
          if (wv[j] && (wa[j] == AWIDTH'(i))) begin
            ent_we[i] = 1'b1;
            ent_wd[i] = wd[j];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = rd_data_q;
    for (int k = 0; k < NRD; k++) begin
      if (rd_en_i[k]) begin
        if (busy) begin
          rd_data_d[k*XLEN +: XLEN] = '0;
        end else if (!addr_ok(ra[k])) begin
          rd_data_d[k*XLEN +: XLEN] = '0;
        end else begin
          rd_data_d[k*XLEN +: XLEN] = mem_q[ra[k]];
`ifdef SCR1_MPRF_MP_FWD_EN
          // Write-first bypass; later ports override earlier ones to match
          // the array's write priority.
          for (int j = 0; j < NWR; j++) begin
            if (wv[j] && (wa[j] == ra[k])) begin
              rd_data_d[k*XLEN +: XLEN] = wd[j];
            end
          end
`endif
        end
      end
    end
  end

  // A drop is reported for any request seen while clearing, even one aimed at
  // an address that would have been discarded anyway.
  assign wr_drop_d = busy && (|wr_req_i);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= FIRST_A;
      rd_data_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Array storage is deliberately not reset; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (ent_we[i]) begin
        mem_q[i] <= ent_wd[i];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign busy_o    = busy;
  assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_scr1_pipe_mprf_mp.sv
// -----------------------------------------------------------------------------
// tb_scr1_pipe_mprf_mp
//
// Directed bench for scr1_pipe_mprf_mp with XLEN=32, SIZE=32, NRD=2, NWR=2,
// ZERO_REG=1. Inputs change 1 ns after a rising edge; outputs are sampled
// 1 ns after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_scr1_pipe_mprf_mp;

  localparam int XLEN   = 32;
  localparam int AWIDTH = 5;
  localparam int SIZE   = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;

  logic                   clk;
  logic                   rst;
  logic [NRD-1:0]         rd_en;
  logic [NRD*AWIDTH-1:0]  rd_addr;
  logic [NRD*XLEN-1:0]    rd_data;
  logic [NWR-1:0]         wr_req;
  logic [NWR*AWIDTH-1:0]  wr_addr;
  logic [NWR*XLEN-1:0]    wr_data;
  logic                   init_req;
  logic                   busy;
  logic                   wr_drop;

  int checks;
  int errors;
  int cnt;
  logic exp_drop;

  scr1_pipe_mprf_mp #(
    .XLEN(XLEN), .AWIDTH(AWIDTH), .SIZE(SIZE),
    .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .init_req_i (init_req),
    .busy_o     (busy),
    .wr_drop_o  (wr_drop)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en    = '0;
    rd_addr  = '0;
    wr_req   = '0;
    wr_addr  = '0;
    wr_data  = '0;
    init_req = 1'b0;
  endtask

  task automatic rd2(input logic [AWIDTH-1:0] a0, input logic [AWIDTH-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
  endtask

  task automatic wr_port(input int p, input logic [AWIDTH-1:0] a, input logic [XLEN-1:0] d);
    wr_req[p]                 = 1'b1;
    wr_addr[p*AWIDTH +: AWIDTH] = a;
    wr_data[p*XLEN +: XLEN]     = d;
  endtask

  function automatic logic [XLEN-1:0] p0();
    return rd_data[0 +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] p1();
    return rd_data[XLEN +: XLEN];
  endfunction

  // ---------------------------------------------------------------- main
  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rdata", 64'(rd_data), 64'd0);
    check("rst_drop", 64'(wr_drop), 64'd0);

    // Clear after reset: 31 cycles with ZERO_REG=1.
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    check("clear_len_reset", 64'(cnt), 64'd31);

    // All entries read zero after the clear.
    for (int a = 0; a < SIZE; a++) begin
      rd2(AWIDTH'(a), AWIDTH'(SIZE - 1 - a));
      step();
      check("clear_zero_p0", 64'(p0()), 64'd0);
      check("clear_zero_p1", 64'(p1()), 64'd0);
    end
    idle_inputs();

    // Basic write then read; port1 reads the hardwired zero entry.
    wr_port(0, 5'd5, 32'hDEADBEEF);
    step();
    idle_inputs();
    rd2(5'd5, 5'd0);
    step();
    check("rd_addr5", 64'(p0()), 64'hDEADBEEF);
    check("rd_addr0", 64'(p1()), 64'd0);
    idle_inputs();

    // Writing entry 0 is discarded.
    wr_port(1, 5'd0, 32'hCAFEF00D);
    step();
    idle_inputs();
    rd2(5'd0, 5'd5);
    step();
    check("zero_reg_wr", 64'(p0()), 64'd0);
    check("rd_addr5_again", 64'(p1()), 64'hDEADBEEF);
    idle_inputs();

    // Same-cycle write/read collision on entry 7.
    wr_port(0, 5'd7, 32'hAAAAAAAA);
    step();
    idle_inputs();
    wr_port(0, 5'd7, 32'h12345678);
    rd2(5'd7, 5'd7);
    step();
`ifdef SCR1_MPRF_MP_FWD_EN
    check("collide_p0", 64'(p0()), 64'h12345678);
    check("collide_p1", 64'(p1()), 64'h12345678);
`else
    check("collide_p0", 64'(p0()), 64'hAAAAAAAA);
    check("collide_p1", 64'(p1()), 64'hAAAAAAAA);
`endif
    idle_inputs();
    rd2(5'd7, 5'd5);
    step();
    check("after_collide", 64'(p0()), 64'h12345678);

    // rd_en low holds the previous data even when the address changes.
    idle_inputs();
    rd_addr = {5'd5, 5'd0};
    step();
    check("hold_p0", 64'(p0()), 64'h12345678);
    check("hold_p1", 64'(p1()), 64'hDEADBEEF);

    // Two write ports on one address: port1 wins.
    wr_port(0, 5'd9, 32'h1);
    wr_port(1, 5'd9, 32'h2);
    step();
    idle_inputs();
    rd2(5'd9, 5'd9);
    step();
    check("wr_prio", 64'(p0()), 64'h2);
    idle_inputs();

    // Double write colliding with a read: forwarded value follows priority.
    wr_port(0, 5'd10, 32'h10);
    wr_port(1, 5'd10, 32'h20);
    rd2(5'd9, 5'd10);
    step();
`ifdef SCR1_MPRF_MP_FWD_EN
    check("fwd_prio", 64'(p1()), 64'h20);
`else
    check("fwd_prio", 64'(p1()), 64'h0);
`endif
    idle_inputs();
    rd2(5'd9, 5'd10);
    step();
    check("after_prio", 64'(p1()), 64'h20);
    check("keep_9", 64'(p0()), 64'h2);
    idle_inputs();

    // init_req in READY; writes during busy are dropped and pulse wr_drop_o.
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    check("init_busy", 64'(busy), 64'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      idle_inputs();
      exp_drop = 1'b0;
      if (cnt == 2) begin
        wr_port(0, 5'd5, 32'hF00DF00D);
        exp_drop = 1'b1;
      end
      if (cnt == 3) begin
        rd_en   = 2'b01;
        rd_addr = {5'd0, 5'd9};
      end
      if (cnt == 5) begin
        wr_port(0, 5'd9, 32'h99);
        wr_port(1, 5'd10, 32'hAA);
        init_req = 1'b1;
        exp_drop = 1'b1;
      end
      step();
      check("drop_busy", 64'(wr_drop), 64'(exp_drop));
      if (cnt == 3) begin
        check("rd_busy_zero", 64'(p0()), 64'd0);
      end
      cnt++;
    end
    idle_inputs();
    check("clear_len_init", 64'(cnt), 64'd31);
    step();
    check("drop_idle", 64'(wr_drop), 64'd0);

    for (int a = 0; a < SIZE; a += 3) begin
      rd2(AWIDTH'(a), AWIDTH'(a + 1));
      step();
      check("reclear_p0", 64'(p0()), 64'd0);
      check("reclear_p1", 64'(p1()), 64'd0);
    end
    rd2(5'd5, 5'd10);
    step();
    check("reclear_5", 64'(p0()), 64'd0);
    check("reclear_10", 64'(p1()), 64'd0);
    idle_inputs();

    // Reset in the middle of a clear restarts the walk.
    wr_port(0, 5'd3, 32'h55);
    step();
    idle_inputs();
    rd2(5'd3, 5'd3);
    step();
    check("pre_rst_rd", 64'(p0()), 64'h55);
    idle_inputs();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
    end
    rst = 1'b1;
    step();
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_rdata", 64'(rd_data), 64'd0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    check("clear_len_midrst", 64'(cnt), 64'd31);
    rd2(5'd3, 5'd31);
    step();
    check("post_rst_3", 64'(p0()), 64'd0);
    check("post_rst_31", 64'(p1()), 64'd0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
